// File: rtl/deferred_ctrl_pkg.sv
// Shared types and defaults for the deferred step controller.
package deferred_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fetch_state_e;

    localparam int DEFAULT_FETCH_INTERVAL = 5000;
    localparam int DEFAULT_FLUSH_INTERVAL = 1000;

    // Width of a core index; a single core still needs one bit on the port.
    function automatic int core_idx_width(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/deferred_step_acc.sv
// One core's step accumulator: saturating sum, force bit and pending flag.
module deferred_step_acc
    import deferred_ctrl_pkg::*;
#(
    parameter int          STEP_WIDTH      = 8,
    parameter int          ACC_WIDTH       = 16,
    parameter int unsigned FLUSH_THRESHOLD = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  clear_on_capture,
    input  logic                  kill,
    input  logic                  force_set,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  pend,
    output logic                  sat
);

    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum;
    logic                 force_q;

    // Next sum: a captured accumulator restarts from this cycle's step so nothing is lost.
    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    always_comb begin
        base = clear_on_capture ? '0 : acc;
        sum  = {1'b0, base} + (ACC_WIDTH + 1)'(step);
    end

    assign sat  = ~kill & sum[ACC_WIDTH];
    assign pend = (32'(acc) >= FLUSH_THRESHOLD) | (force_q & (acc != '0));

    // Accumulator and force bit; kill (simulation finished) empties the channel.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            force_q <= 1'b0;
        end else if (kill) begin
            acc     <= '0;
            force_q <= 1'b0;
        end else begin
            acc <= sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
            if (clear_on_capture) begin
                force_q <= 1'b0;
            end else if (force_set && (acc != '0)) begin
                force_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/deferred_step_ctrl.sv
// Batches per-core step counts into round-robin nstep transactions and
// polls the simulation result on a fixed interval.
module deferred_step_ctrl
    import deferred_ctrl_pkg::*;
#(
    parameter int          NUM_CORES       = 2,
    parameter int          STEP_WIDTH      = 8,
    parameter int          ACC_WIDTH       = 16,
    parameter int          FETCH_INTERVAL  = DEFAULT_FETCH_INTERVAL,
    parameter int unsigned FLUSH_THRESHOLD = 64,
    parameter int          FLUSH_INTERVAL  = DEFAULT_FLUSH_INTERVAL,
    parameter int          FETCH_SYNC      = 1
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0]          step,
    output logic                                     nstep_valid,
    input  logic                                     nstep_ready,
    output logic [core_idx_width(NUM_CORES)-1:0]     nstep_core,
    output logic [ACC_WIDTH-1:0]                     nstep_count,
    output logic                                     fetch_valid,
    input  logic                                     fetch_ready,
    input  logic                                     resp_valid,
    input  logic                                     resp_result,
    output logic                                     simv_result,
    output logic                                     overflow_err
);

    localparam int IDX_W   = core_idx_width(NUM_CORES);
    localparam int FETCH_W = $clog2(FETCH_INTERVAL);
    localparam int FLUSH_W = (FLUSH_INTERVAL > 1) ? $clog2(FLUSH_INTERVAL) : 1;

    logic [ACC_WIDTH-1:0] acc [NUM_CORES];
    logic [NUM_CORES-1:0] pend;
    logic [NUM_CORES-1:0] sat;
    logic [NUM_CORES-1:0] clear_vec;
    logic                 force_set;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     probe;
    int                   probe_sum;
    logic                 found;
    logic                 capture_en;
    logic                 acc_zero;
    logic                 sync_ok;

    fetch_state_e         state;
    fetch_state_e         state_next;
    logic [FETCH_W-1:0]   fetch_cnt;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic                 fetch_at_limit;
    logic                 flush_wrap;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        deferred_step_acc #(
            .STEP_WIDTH      (STEP_WIDTH),
            .ACC_WIDTH       (ACC_WIDTH),
            .FLUSH_THRESHOLD (FLUSH_THRESHOLD)
        ) u_acc (
            .clock            (clock),
            .reset            (reset),
            .step             (step[g*STEP_WIDTH +: STEP_WIDTH]),
            .clear_on_capture (clear_vec[g]),
            .kill             (simv_result),
            .force_set        (force_set),
            .acc              (acc[g]),
            .pend             (pend[g]),
            .sat              (sat[g])
        );
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        found     = 1'b0;
        winner    = rr_ptr;
        probe     = '0;
        probe_sum = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            probe_sum = int'(rr_ptr) + k;
            if (probe_sum >= NUM_CORES) begin
                probe_sum = probe_sum - NUM_CORES;
            end
            probe = IDX_W'(probe_sum);
            if (!found && pend[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

    assign capture_en = (~nstep_valid | nstep_ready) & found & ~simv_result;

    // One-hot restart for the winning accumulator and the fetch sync condition.
    always_comb begin
        clear_vec = '0;
        if (capture_en) begin
            clear_vec[winner] = 1'b1;
        end
        acc_zero = 1'b1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (acc[i] != '0) begin
                acc_zero = 1'b0;
            end
        end
    end

    assign sync_ok        = (FETCH_SYNC == 0) | (acc_zero & ~nstep_valid);
    assign fetch_at_limit = (fetch_cnt == FETCH_W'(FETCH_INTERVAL - 1));
    assign flush_wrap     = (flush_cnt == FLUSH_W'(FLUSH_INTERVAL - 1));
    // A fetch held back by sync drains every nonzero accumulator.
    assign force_set      = flush_wrap | ((state == IDLE) & fetch_at_limit & ~sync_ok);

    // Free-running flush timer that forces out stale small counts.
    always_ff @(posedge clock) begin
        if (reset || flush_wrap) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt + FLUSH_W'(1);
        end
    end

    // Output register: load on capture, otherwise hold until accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            nstep_valid <= 1'b0;
            nstep_core  <= '0;
            nstep_count <= '0;
            rr_ptr      <= '0;
        end else if (capture_en) begin
            nstep_valid <= 1'b1;
            nstep_core  <= winner;
            nstep_count <= acc[winner];
            rr_ptr      <= winner;
        end else if (nstep_ready) begin
            nstep_valid <= 1'b0;
        end
    end

    // Sticky saturation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_err <= 1'b0;
        end else if (|sat) begin
            overflow_err <= 1'b1;
        end
    end

    // Fetch state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch timer and sticky result; the timer only runs in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt   <= '0;
            simv_result <= 1'b0;
        end else begin
            if (state == IDLE && !fetch_at_limit) begin
                fetch_cnt <= fetch_cnt + FETCH_W'(1);
            end
            if (state == WAIT && resp_valid) begin
                fetch_cnt <= '0;
                if (resp_result) begin
                    simv_result <= 1'b1;
                end
            end
        end
    end

    // Fetch next-state and request output.
    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_at_limit && sync_ok) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                fetch_valid = 1'b1;
                if (fetch_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    state_next = resp_result ? DONE : IDLE;
                end
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_deferred_step_ctrl.sv
// Directed bench for deferred_step_ctrl: threshold flush, round-robin with
// backpressure, forced flush, fetch cadence, finish and saturation.
module tb_deferred_step_ctrl;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // Instance A: 16-bit accumulators, short intervals, unsynchronised fetch.
    logic [15:0] a_step;
    logic        a_nstep_ready, a_fetch_ready, a_resp_valid, a_resp_result;
    logic        a_nstep_valid, a_nstep_core, a_fetch_valid, a_simv_result, a_overflow_err;
    logic [15:0] a_nstep_count;

    // Instance B: 9-bit accumulators with an unreachable threshold.
    logic [15:0] b_step;
    logic        b_nstep_ready, b_fetch_ready, b_resp_valid, b_resp_result;
    logic        b_nstep_valid, b_nstep_core, b_fetch_valid, b_simv_result, b_overflow_err;
    logic [8:0]  b_nstep_count;

    int errors = 0;
    int checks = 0;
    int n;
    int cnt;
    int hs;

    deferred_step_ctrl #(
        .NUM_CORES(2), .STEP_WIDTH(8), .ACC_WIDTH(16), .FETCH_INTERVAL(50),
        .FLUSH_THRESHOLD(64), .FLUSH_INTERVAL(100), .FETCH_SYNC(0)
    ) dut_a (
        .clock(clock), .reset(reset), .step(a_step),
        .nstep_valid(a_nstep_valid), .nstep_ready(a_nstep_ready),
        .nstep_core(a_nstep_core), .nstep_count(a_nstep_count),
        .fetch_valid(a_fetch_valid), .fetch_ready(a_fetch_ready),
        .resp_valid(a_resp_valid), .resp_result(a_resp_result),
        .simv_result(a_simv_result), .overflow_err(a_overflow_err)
    );

    deferred_step_ctrl #(
        .NUM_CORES(2), .STEP_WIDTH(8), .ACC_WIDTH(9), .FETCH_INTERVAL(5000),
        .FLUSH_THRESHOLD(600), .FLUSH_INTERVAL(200), .FETCH_SYNC(1)
    ) dut_b (
        .clock(clock), .reset(reset), .step(b_step),
        .nstep_valid(b_nstep_valid), .nstep_ready(b_nstep_ready),
        .nstep_core(b_nstep_core), .nstep_count(b_nstep_count),
        .fetch_valid(b_fetch_valid), .fetch_ready(b_fetch_ready),
        .resp_valid(b_resp_valid), .resp_result(b_resp_result),
        .simv_result(b_simv_result), .overflow_err(b_overflow_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        a_step        = '0;
        a_nstep_ready = 1'b0;
        a_fetch_ready = 1'b0;
        a_resp_valid  = 1'b0;
        a_resp_result = 1'b0;
        b_step        = '0;
        b_nstep_ready = 1'b0;
        b_fetch_ready = 1'b0;
        b_resp_valid  = 1'b0;
        b_resp_result = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        do_reset();
        check("rst_nstep_valid", 32'(a_nstep_valid), 32'd0);
        check("rst_nstep_core", 32'(a_nstep_core), 32'd0);
        check("rst_nstep_count", 32'(a_nstep_count), 32'd0);
        check("rst_fetch_valid", 32'(a_fetch_valid), 32'd0);
        check("rst_simv_result", 32'(a_simv_result), 32'd0);
        check("rst_overflow_err", 32'(a_overflow_err), 32'd0);

        // Threshold flush: 8 x 8 on core0 reaches exactly 64.
        a_nstep_ready = 1'b1;
        a_step = {8'd0, 8'd8};
        for (int i = 0; i < 8; i++) tick();
        check("thr_not_early", 32'(a_nstep_valid), 32'd0);
        a_step = '0;
        tick();
        check("thr_valid", 32'(a_nstep_valid), 32'd1);
        check("thr_core", 32'(a_nstep_core), 32'd0);
        check("thr_count", 32'(a_nstep_count), 32'd64);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_nstep_valid) cnt++;
        end
        check("thr_single_txn", 32'(cnt), 32'd0);

        // Prime the round-robin pointer with a core1 transaction.
        a_step = {8'd64, 8'd0};
        tick();
        a_step = '0;
        tick();
        check("prime_core", 32'(a_nstep_core), 32'd1);
        check("prime_count", 32'(a_nstep_count), 32'd64);
        tick();
        check("prime_drop", 32'(a_nstep_valid), 32'd0);

        // Both cores reach 64 together; core0 wins and stalls, core1 keeps accumulating.
        a_nstep_ready = 1'b0;
        a_step = {8'd64, 8'd64};
        tick();
        check("rr_no_capture_yet", 32'(a_nstep_valid), 32'd0);
        a_step = {8'd5, 8'd0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_stall_valid", 32'(a_nstep_valid), 32'd1);
            check("rr_stall_core", 32'(a_nstep_core), 32'd0);
            check("rr_stall_count", 32'(a_nstep_count), 32'd64);
        end
        a_step = '0;
        a_nstep_ready = 1'b1;
        tick();
        check("rr_next_valid", 32'(a_nstep_valid), 32'd1);
        check("rr_next_core", 32'(a_nstep_core), 32'd1);
        check("rr_next_count", 32'(a_nstep_count), 32'd89);
        tick();
        check("rr_drain", 32'(a_nstep_valid), 32'd0);

        // Forced flush of a small count after the flush interval wraps.
        do_reset();
        a_nstep_ready = 1'b1;
        a_step = {8'd3, 8'd0};
        tick();
        a_step = '0;
        n = 0;
        for (int i = 1; i <= 102; i++) begin
            tick();
            if (a_nstep_valid) begin
                n = i;
                break;
            end
        end
        check("force_latency", 32'(n), 32'd100);
        check("force_core", 32'(a_nstep_core), 32'd1);
        check("force_count", 32'(a_nstep_count), 32'd3);

        // Fetch cadence with an unfinished response.
        do_reset();
        a_fetch_ready = 1'b1;
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (a_fetch_valid) begin
                n = i;
                break;
            end
        end
        check("fetch_first", 32'(n), 32'd50);
        tick();
        check("fetch_accepted", 32'(a_fetch_valid), 32'd0);
        tick();
        tick();
        a_resp_valid  = 1'b1;
        a_resp_result = 1'b0;
        tick();
        a_resp_result = 1'b1;
        tick();
        a_resp_valid  = 1'b0;
        a_resp_result = 1'b0;
        check("resp_outside_wait", 32'(a_simv_result), 32'd0);
        n = 0;
        for (int i = 2; i <= 60; i++) begin
            tick();
            if (a_fetch_valid) begin
                n = i;
                break;
            end
        end
        check("fetch_second", 32'(n), 32'd50);

        // Finish while a core1 transaction is stalled and core0 holds 20.
        do_reset();
        a_step = {8'd64, 8'd0};
        tick();
        a_step = {8'd0, 8'd20};
        tick();
        a_step = '0;
        check("fin_stalled_valid", 32'(a_nstep_valid), 32'd1);
        check("fin_stalled_core", 32'(a_nstep_core), 32'd1);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (a_fetch_valid) begin
                n = i;
                break;
            end
        end
        check("fin_fetch_seen", 32'(n != 0), 32'd1);
        a_fetch_ready = 1'b1;
        tick();
        a_fetch_ready = 1'b0;
        a_resp_valid  = 1'b1;
        a_resp_result = 1'b1;
        tick();
        a_resp_valid  = 1'b0;
        a_resp_result = 1'b0;
        check("fin_simv", 32'(a_simv_result), 32'd1);
        check("fin_hold_valid", 32'(a_nstep_valid), 32'd1);
        check("fin_hold_count", 32'(a_nstep_count), 32'd64);
        a_nstep_ready = 1'b1;
        a_fetch_ready = 1'b1;
        hs  = 0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (a_nstep_valid && a_nstep_ready) hs++;
            a_step = 16'($urandom);
            tick();
            if (a_nstep_valid || a_fetch_valid) cnt++;
        end
        check("fin_one_completion", 32'(hs), 32'd1);
        check("fin_quiet", 32'(cnt), 32'd0);
        check("fin_sticky", 32'(a_simv_result), 32'd1);
        do_reset();
        check("fin_reset_simv", 32'(a_simv_result), 32'd0);

        // Saturation: 255 + 255 = 510 fits, + 255 saturates at 511.
        b_step = {8'd0, 8'd255};
        tick();
        tick();
        check("sat_510_ok", 32'(b_overflow_err), 32'd0);
        tick();
        check("sat_flag", 32'(b_overflow_err), 32'd1);
        b_step = '0;
        b_nstep_ready = 1'b1;
        n = 0;
        for (int i = 1; i <= 250; i++) begin
            tick();
            if (b_nstep_valid) begin
                n = i;
                break;
            end
        end
        check("sat_flush_seen", 32'(n != 0), 32'd1);
        check("sat_core", 32'(b_nstep_core), 32'd0);
        check("sat_count", 32'(b_nstep_count), 32'd511);
        do_reset();
        check("sat_reset_flag", 32'(b_overflow_err), 32'd0);
        check("sat_reset_valid", 32'(b_nstep_valid), 32'd0);
        check("sat_reset_count", 32'(b_nstep_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
